pcm_encoder_mc: RTL and testbench
=================================

// Module: pcm_encoder_mc
// PURPOSE
// - NUM_CH-lane PCM line encoder, successor to the single-lane PCM encoder in the PN generator path.
// - Each lane has its own code, invert and enable, and shares the clkEn / sym2xClkEn / symClkEn timing.
// - Sits between the per-lane NRZ bit sources (PN gen / framer) and the output mux / DAC path.
// - Adds a bit-consume strobe for the sources and glitch-free mode changes at bit boundaries.
// PARAMETERS
// - NUM_CH  4  number of independent lanes, 1..16
// - MODE_W  4  width of each lane's mode field
// PORTS
// - clk             in   1            system clock
// - reset           in   1            synchronous, active-high
// - clkEn           in   1            master clock enable; all state frozen while low
// - sym2xClkEn      in   1            half-bit strobe (qualified by clkEn)
// - symClkEn        in   1            bit-boundary strobe; always coincident with sym2xClkEn
// - nrzBits         in   NUM_CH       NRZ data, lane i on bit i, sampled at a bit boundary
// - pcmMode         in   MODE_W*NUM_CH  lane i code at [MODE_W*i +: MODE_W]
// - pcmInvert       in   NUM_CH       per-lane output polarity invert
// - chEnable        in   NUM_CH       per-lane enable; 0 = output held 0, state cleared
// - pcmRandomize    in   NUM_CH       per-lane RNRZ scrambler select (macro-gated)
// - bitTaken        out  1            1-clk pulse: nrzBits consumed this boundary
// - pcmBits         out  NUM_CH       encoded line outputs, registered
// BEHAVIOUR
// - Reset: pcmBits=0, bitTaken=0, mode shadows=NRZL, level/diff/prev state=0, secondHalf=0, LFSR=0.
// - Boundary B = clkEn&symClkEn. Mid-bit M = clkEn&sym2xClkEn&!symClkEn.
// - bitTaken = B registered; sources advance on it.
// - Mode codes: 0 NRZL, 1 NRZM, 2 NRZS, 3 BIPL, 4 BIPM, 5 BIPS, 6 DMM, 7 DMS.
// - Codes 8-15 behave as NRZL with invert ignored.
// - pcmMode, pcmInvert and pcmRandomize are shadowed per lane on B only.
// - Changes between boundaries take effect at the next boundary. No mid-bit glitch.
// - Per-lane input bit d is nrzBits[i], or the scrambled bit when RNRZ is active. Level L = lane output state.
// - NRZL: L=d at B.
// - NRZM: at B, L toggles if d=1.
// - NRZS: at B, L toggles if d=0.
// - BIPL: at B L=d; at M L=~d.
// - BIPM: toggle L at every B; toggle again at M if d=1.
// - BIPS: toggle L at every B; toggle again at M if d=0.
// - DMM: toggle at M if d=1; toggle at B if d=0 and previous d=0.
// - DMS: same as DMM on ~d.
// - Previous-bit state is updated at B in every mode. Switching modes keeps L, so no forced edge.
// - pcmBits[i] = L ^ invert_shadow, registered. Output changes 1 clk after the B/M strobe.
// - NRZ codes ignore M.
// - chEnable[i]=0: pcmBits[i]=0, and L, prev-d and LFSR for lane i are cleared synchronously.
// - Re-enable starts cleanly at the next B.
// - B without a preceding M, i.e. a short bit, is legal: the second-half action is skipped.
// - Two M strobes in one bit: the second M is ignored, tracked by a per-bit secondHalf flag.
// - clkEn low freezes everything, including the bitTaken register.
// - Reset mid-bit returns to reset state. The first B after reset encodes normally.
// CONFIGURATION
// - PCM_RNRZ_EN defined: per-lane 15-bit IRIG-106 RNRZ scrambler, x^15+x^14+1, self-synchronising.
//   - Output bit: d = nrz ^ sr[13] ^ sr[14].
//   - Shift: sr <= {sr[13:0], d} at B when the lane's randomize shadow is 1.
//   - Shadow=0: sr holds and d = nrz.
// - PCM_RNRZ_EN undefined: no scrambler logic; pcmRandomize ignored, d = nrzBits[i].
// TESTING
// - Reset, NUM_CH=4, all NRZL, nrz=4'b1010 at B -> pcmBits=4'b1010 one clk later; bitTaken pulses once per B.
// - Lane0 NRZM, 8 bits of 1, then 0 -> output toggles at each B for 8 bits, then holds.
//   - Lane0 NRZS with the same data -> holds, then toggles once.
// - Lane1 BIPL, bits 1,0 -> levels 1,0,0,1 on consecutive half-bits.
//   - BIPM, bits 1,1 from L=0 -> levels 1,0,1,0.
// - Lane2 DMM, bits 1,0,0,1 from L=0 -> half-bits 0,1 | 1,1 | 0,0 | 0,1.
//   - DMS on the inverted data -> identical waveform.
// - Mode written 0->3 mid-bit -> no output change until the next B; pcmInvert toggled mid-bit likewise deferred.
// - chEnable[3] dropped mid-bit -> pcmBits[3]=0 next clk; re-enabled, NRZM with 1 -> first toggle starts from 0.
// - With PCM_RNRZ_EN: lane randomized from sr=0 with all-ones input -> 15-bit-period-derived pattern.
//   - Descrambled by a reference model equals the input.
//   - Without the macro the output equals NRZL.

Source files
------------

// File: rtl/pcm_encoder_mc_if.sv
// pcm_encoder_mc_if: shared bit-timing strobes, per-lane controls
// and encoded line outputs of the multi-lane PCM encoder.
interface pcm_encoder_mc_if #(
  parameter int NUM_CH = 4,
  parameter int MODE_W = 4
);
  logic                     clkEn;
  logic                     sym2xClkEn;
  logic                     symClkEn;
  logic [NUM_CH-1:0]        nrzBits;
  logic [MODE_W*NUM_CH-1:0] pcmMode;
  logic [NUM_CH-1:0]        pcmInvert;
  logic [NUM_CH-1:0]        chEnable;
  logic [NUM_CH-1:0]        pcmRandomize;
  logic                     bitTaken;
  logic [NUM_CH-1:0]        pcmBits;

  modport master (
    output clkEn, sym2xClkEn, symClkEn,
    output nrzBits, pcmMode, pcmInvert,
    output chEnable, pcmRandomize,
    input  bitTaken, pcmBits
  );

  modport slave (
    input  clkEn, sym2xClkEn, symClkEn,
    input  nrzBits, pcmMode, pcmInvert,
    input  chEnable, pcmRandomize,
    output bitTaken, pcmBits
  );
endinterface

// File: rtl/pcm_encoder_mc.sv
// pcm_encoder_mc: NUM_CH-lane PCM line encoder (NRZ/BIP/DM codes).
// Define PCM_RNRZ_EN to add a per-lane 15-bit RNRZ scrambler.
module pcm_encoder_mc #(
  parameter int NUM_CH = 4,
  parameter int MODE_W = 4
) (
  input logic             clk,
  input logic             reset,
  pcm_encoder_mc_if.slave bus
);
  typedef enum logic [2:0] {
    NRZL, NRZM, NRZS, BIPL, BIPM, BIPS, DMM, DMS
  } code_e;

  logic b;
  logic m;
  logic doM;
  logic secondHalf;

  logic [MODE_W-1:0] modeSh [NUM_CH];
  logic [MODE_W-1:0] modeNx [NUM_CH];
  code_e             code   [NUM_CH];
  logic [NUM_CH-1:0] invSh, invNx;
  logic [NUM_CH-1:0] lvl, lvlNx;
  logic [NUM_CH-1:0] prevD, prevNx;
  logic [NUM_CH-1:0] curD, curNx;
  logic [NUM_CH-1:0] live, liveNx;
  logic [NUM_CH-1:0] outNx;
  logic [NUM_CH-1:0] dIn;
  logic [NUM_CH-1:0] eNow, ePrev, eCur;

`ifdef PCM_RNRZ_EN
  logic [14:0]       sr   [NUM_CH];
  logic [14:0]       srNx [NUM_CH];
  logic [NUM_CH-1:0] rndSh, rndNx;
`else
  logic unusedRnd;
  assign unusedRnd = ^bus.pcmRandomize;
`endif

  assign b   = bus.clkEn & bus.symClkEn;
  assign m   = bus.clkEn & bus.sym2xClkEn & ~bus.symClkEn;
  assign doM = m & ~secondHalf;

  // Codes 8 and up fall back to plain NRZL with polarity forced
  function automatic logic isRaw(input logic [MODE_W-1:0] md);
    return md > MODE_W'(7);
  endfunction

  function automatic code_e codeOf(input logic [MODE_W-1:0] md);
    return isRaw(md) ? NRZL : code_e'(md[2:0]);
  endfunction

  always_comb begin
    dIn    = bus.nrzBits;
    modeNx = modeSh;
    invNx  = b ? bus.pcmInvert : invSh;
    lvlNx  = lvl;
    prevNx = prevD;
    curNx  = curD;
    liveNx = live;
    outNx  = '0;
    eNow   = '0;
    ePrev  = '0;
    eCur   = '0;
`ifdef PCM_RNRZ_EN
    rndNx  = b ? bus.pcmRandomize : rndSh;
    srNx   = sr;
`endif
    for (int i = 0; i < NUM_CH; i++) begin
      if (b) modeNx[i] = bus.pcmMode[MODE_W*i +: MODE_W];
`ifdef PCM_RNRZ_EN
      if (rndNx[i])
        dIn[i] = bus.nrzBits[i] ^ sr[i][13] ^ sr[i][14];
      if (b && rndNx[i])
        srNx[i] = {sr[i][13:0], dIn[i]};
`endif
      code[i]  = codeOf(modeNx[i]);
      eNow[i]  = (code[i] == DMS) ? ~dIn[i]   : dIn[i];
      ePrev[i] = (code[i] == DMS) ? ~prevD[i] : prevD[i];
      eCur[i]  = (code[i] == DMS) ? ~curD[i]  : curD[i];
      unique case (1'b1)
        b: begin
          curNx[i]  = dIn[i];
          prevNx[i] = dIn[i];
          liveNx[i] = 1'b1;
          unique case (code[i])
            NRZL, BIPL: lvlNx[i] = dIn[i];
            NRZM:       lvlNx[i] = lvl[i] ^ dIn[i];
            NRZS:       lvlNx[i] = lvl[i] ^ ~dIn[i];
            BIPM, BIPS: lvlNx[i] = ~lvl[i];
            DMM, DMS:   lvlNx[i] = lvl[i] ^ (~eNow[i] & ~ePrev[i]);
          endcase
        end
        doM && live[i]: begin
          unique case (code[i])
            BIPL:     lvlNx[i] = ~curD[i];
            BIPM:     lvlNx[i] = lvl[i] ^ curD[i];
            BIPS:     lvlNx[i] = lvl[i] ^ ~curD[i];
            DMM, DMS: lvlNx[i] = lvl[i] ^ eCur[i];
            default:  lvlNx[i] = lvl[i];
          endcase
        end
        default: ;
      endcase
      // A disabled lane stays idle until the first boundary after re-enable
      if (!bus.chEnable[i]) begin
        lvlNx[i]  = 1'b0;
        prevNx[i] = 1'b0;
        curNx[i]  = 1'b0;
        liveNx[i] = 1'b0;
`ifdef PCM_RNRZ_EN
        srNx[i]   = '0;
`endif
      end
      outNx[i] = liveNx[i] &
                 (lvlNx[i] ^ (invNx[i] & ~isRaw(modeNx[i])));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.bitTaken <= 1'b0;
      bus.pcmBits  <= '0;
      secondHalf   <= 1'b0;
      modeSh       <= '{default: '0};
      invSh        <= '0;
      lvl          <= '0;
      prevD        <= '0;
      curD         <= '0;
      live         <= '0;
`ifdef PCM_RNRZ_EN
      rndSh        <= '0;
      sr           <= '{default: '0};
`endif
    end else begin
      if (bus.clkEn) bus.bitTaken <= bus.symClkEn;
      if (b)      secondHalf <= 1'b0;
      else if (m) secondHalf <= 1'b1;
      bus.pcmBits <= outNx;
      modeSh      <= modeNx;
      invSh       <= invNx;
      lvl         <= lvlNx;
      prevD       <= prevNx;
      curD        <= curNx;
      live        <= liveNx;
`ifdef PCM_RNRZ_EN
      rndSh       <= rndNx;
      sr          <= srNx;
`endif
    end
  end
endmodule

// File: tb/tb_pcm_encoder_mc.sv
// tb_pcm_encoder_mc: scoreboard bench for the multi-lane PCM encoder.
// Expected line levels are queued at stimulus and popped after each strobe.
module tb_pcm_encoder_mc;
  localparam int NCH = 4;
  localparam int MW  = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pcm_encoder_mc_if #(.NUM_CH(NCH), .MODE_W(MW)) bus ();

  pcm_encoder_mc #(.NUM_CH(NCH), .MODE_W(MW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int nChecks = 0;
  int nFails  = 0;
  logic           expQ  [$];
  logic [NCH-1:0] expVQ [$];

  task automatic tick();
    @(posedge clk);
    #1;
    bus.sym2xClkEn = 1'b0;
    bus.symClkEn   = 1'b0;
  endtask

  task automatic bnd();
    bus.sym2xClkEn = 1'b1;
    bus.symClkEn   = 1'b1;
    tick();
  endtask

  task automatic mid();
    bus.sym2xClkEn = 1'b1;
    bus.symClkEn   = 1'b0;
    tick();
  endtask

  task automatic setMode(input int ch, input int md);
    bus.pcmMode[MW*ch +: MW] = MW'(md);
  endtask

  task automatic do_reset();
    reset            = 1'b1;
    bus.clkEn        = 1'b1;
    bus.chEnable     = '1;
    bus.pcmMode      = '0;
    bus.pcmInvert    = '0;
    bus.pcmRandomize = '0;
    bus.nrzBits      = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    reset = 1'b1;
    bus.nrzBits = '1;
    bnd();
    bnd();
    nChecks++;
    if (bus.pcmBits !== 4'b0000) begin
      nFails++;
      $display("FAIL reset_pcm: got %b want 0000", bus.pcmBits);
    end
    nChecks++;
    if (bus.bitTaken !== 1'b0) begin
      nFails++;
      $display("FAIL reset_taken: got %b want 0", bus.bitTaken);
    end
    reset = 1'b0;
    tick();
    nChecks++;
    if (bus.pcmBits !== 4'b0000) begin
      nFails++;
      $display("FAIL reset_idle: got %b want 0000", bus.pcmBits);
    end
  endtask

  task automatic test_nrzl();
    logic [NCH-1:0] ev;
    do_reset();
    bus.nrzBits = 4'b1010;
    expVQ.push_back(4'b1010);
    bnd();
    bus.nrzBits = 4'b0101;
    ev = expVQ.pop_front();
    nChecks++;
    if (bus.pcmBits !== ev) begin
      nFails++;
      $display("FAIL nrzl_out: got %b want %b", bus.pcmBits, ev);
    end
    nChecks++;
    if (bus.bitTaken !== 1'b1) begin
      nFails++;
      $display("FAIL taken_pulse: got %b want 1", bus.bitTaken);
    end
    tick();
    nChecks++;
    if (bus.bitTaken !== 1'b0) begin
      nFails++;
      $display("FAIL taken_clear: got %b want 0", bus.bitTaken);
    end
    nChecks++;
    if (bus.pcmBits !== 4'b1010) begin
      nFails++;
      $display("FAIL nrzl_hold: got %b want 1010", bus.pcmBits);
    end
    expVQ.push_back(4'b0101);
    bnd();
    bus.clkEn = 1'b0;
    bus.nrzBits = 4'b1111;
    bus.sym2xClkEn = 1'b1;
    bus.symClkEn = 1'b1;
    tick();
    ev = expVQ.pop_front();
    nChecks++;
    if (bus.pcmBits !== ev) begin
      nFails++;
      $display("FAIL freeze_pcm: got %b want %b", bus.pcmBits, ev);
    end
    nChecks++;
    if (bus.bitTaken !== 1'b1) begin
      nFails++;
      $display("FAIL freeze_taken: got %b want 1", bus.bitTaken);
    end
    bus.clkEn = 1'b1;
    tick();
    nChecks++;
    if (bus.bitTaken !== 1'b0) begin
      nFails++;
      $display("FAIL unfreeze_taken: got %b want 0", bus.bitTaken);
    end
  endtask

  task automatic test_nrzm_nrzs();
    logic ex;
    logic e;
    logic d;
    do_reset();
    setMode(0, 1);
    ex = 1'b0;
    for (int k = 0; k < 10; k++) begin
      d = (k < 8);
      bus.nrzBits[0] = d;
      ex = ex ^ d;
      expQ.push_back(ex);
      bnd();
      e = expQ.pop_front();
      nChecks++;
      if (bus.pcmBits[0] !== e) begin
        nFails++;
        $display("FAIL nrzm[%0d]: got %b want %b", k, bus.pcmBits[0], e);
      end
      expQ.push_back(ex);
      mid();
      e = expQ.pop_front();
      nChecks++;
      if (bus.pcmBits[0] !== e) begin
        nFails++;
        $display("FAIL nrzm_mid[%0d]: got %b want %b", k, bus.pcmBits[0], e);
      end
    end
    do_reset();
    setMode(0, 2);
    ex = 1'b0;
    for (int k = 0; k < 9; k++) begin
      d = (k < 8);
      bus.nrzBits[0] = d;
      ex = ex ^ ~d;
      expQ.push_back(ex);
      bnd();
      mid();
      e = expQ.pop_front();
      nChecks++;
      if (bus.pcmBits[0] !== e) begin
        nFails++;
        $display("FAIL nrzs[%0d]: got %b want %b", k, bus.pcmBits[0], e);
      end
    end
  endtask

  task automatic test_biphase();
    logic [1:0] bv;
    logic [3:0] hv;
    logic e;
    do_reset();
    setMode(1, 3);
    bv = 2'b01;
    hv = 4'b1001;
    for (int k = 0; k < 2; k++) begin
      bus.nrzBits[1] = bv[k];
      expQ.push_back(hv[2*k]);
      bnd();
      e = expQ.pop_front();
      nChecks++;
      if (bus.pcmBits[1] !== e) begin
        nFails++;
        $display("FAIL bipl_b[%0d]: got %b want %b", k, bus.pcmBits[1], e);
      end
      expQ.push_back(hv[2*k+1]);
      mid();
      e = expQ.pop_front();
      nChecks++;
      if (bus.pcmBits[1] !== e) begin
        nFails++;
        $display("FAIL bipl_m[%0d]: got %b want %b", k, bus.pcmBits[1], e);
      end
    end
    do_reset();
    setMode(1, 4);
    bv = 2'b11;
    hv = 4'b0101;
    for (int k = 0; k < 2; k++) begin
      bus.nrzBits[1] = bv[k];
      expQ.push_back(hv[2*k]);
      bnd();
      e = expQ.pop_front();
      nChecks++;
      if (bus.pcmBits[1] !== e) begin
        nFails++;
        $display("FAIL bipm_b[%0d]: got %b want %b", k, bus.pcmBits[1], e);
      end
      expQ.push_back(hv[2*k+1]);
      mid();
      e = expQ.pop_front();
      nChecks++;
      if (bus.pcmBits[1] !== e) begin
        nFails++;
        $display("FAIL bipm_m[%0d]: got %b want %b", k, bus.pcmBits[1], e);
      end
    end
    mid();
    nChecks++;
    if (bus.pcmBits[1] !== 1'b0) begin
      nFails++;
      $display("FAIL bipm_double_m: got %b want 0", bus.pcmBits[1]);
    end
    bnd();
    bnd();
    nChecks++;
    if (bus.pcmBits[1] !== 1'b0) begin
      nFails++;
      $display("FAIL bipm_short: got %b want 0", bus.pcmBits[1]);
    end
    mid();
    nChecks++;
    if (bus.pcmBits[1] !== 1'b1) begin
      nFails++;
      $display("FAIL bipm_after_short: got %b want 1", bus.pcmBits[1]);
    end
  endtask

  task automatic test_dm();
    logic [3:0] bv;
    logic [7:0] hv;
    logic e;
    hv = 8'b1000_1110;
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      setMode(2, pass == 0 ? 6 : 7);
      bv = (pass == 0) ? 4'b1001 : 4'b0110;
      for (int k = 0; k < 4; k++) begin
        bus.nrzBits[2] = bv[k];
        expQ.push_back(hv[2*k]);
        bnd();
        e = expQ.pop_front();
        nChecks++;
        if (bus.pcmBits[2] !== e) begin
          nFails++;
          $display("FAIL dm%0d_b[%0d]: got %b want %b",
                   pass, k, bus.pcmBits[2], e);
        end
        expQ.push_back(hv[2*k+1]);
        mid();
        e = expQ.pop_front();
        nChecks++;
        if (bus.pcmBits[2] !== e) begin
          nFails++;
          $display("FAIL dm%0d_m[%0d]: got %b want %b",
                   pass, k, bus.pcmBits[2], e);
        end
      end
    end
  endtask

  task automatic test_deferred();
    logic e;
    logic [5:0] ev;
    ev = 6'b01_1_0_11;
    do_reset();
    bus.nrzBits[0] = 1'b1;
    bnd();
    setMode(0, 3);
    bus.pcmInvert[0] = 1'b1;
    tick();
    expQ.push_back(ev[0]);
    mid();
    e = expQ.pop_front();
    nChecks++;
    if (bus.pcmBits[0] !== e) begin
      nFails++;
      $display("FAIL defer_mid: got %b want %b", bus.pcmBits[0], e);
    end
    expQ.push_back(ev[2]);
    bnd();
    e = expQ.pop_front();
    nChecks++;
    if (bus.pcmBits[0] !== e) begin
      nFails++;
      $display("FAIL defer_b: got %b want %b", bus.pcmBits[0], e);
    end
    expQ.push_back(ev[3]);
    mid();
    e = expQ.pop_front();
    nChecks++;
    if (bus.pcmBits[0] !== e) begin
      nFails++;
      $display("FAIL defer_m: got %b want %b", bus.pcmBits[0], e);
    end
    setMode(0, 9);
    expQ.push_back(ev[4]);
    bnd();
    e = expQ.pop_front();
    nChecks++;
    if (bus.pcmBits[0] !== e) begin
      nFails++;
      $display("FAIL raw_code_one: got %b want %b", bus.pcmBits[0], e);
    end
    bus.nrzBits[0] = 1'b0;
    expQ.push_back(ev[5]);
    bnd();
    e = expQ.pop_front();
    nChecks++;
    if (bus.pcmBits[0] !== e) begin
      nFails++;
      $display("FAIL raw_code_zero: got %b want %b", bus.pcmBits[0], e);
    end
  endtask

  task automatic test_enable();
    do_reset();
    setMode(3, 1);
    bus.nrzBits = 4'b1001;
    bnd();
    nChecks++;
    if (bus.pcmBits !== 4'b1001) begin
      nFails++;
      $display("FAIL en_start: got %b want 1001", bus.pcmBits);
    end
    bus.chEnable[3] = 1'b0;
    tick();
    nChecks++;
    if (bus.pcmBits !== 4'b0001) begin
      nFails++;
      $display("FAIL en_drop: got %b want 0001", bus.pcmBits);
    end
    mid();
    bnd();
    nChecks++;
    if (bus.pcmBits[3] !== 1'b0) begin
      nFails++;
      $display("FAIL en_off_b: got %b want 0", bus.pcmBits[3]);
    end
    bus.chEnable[3] = 1'b1;
    tick();
    mid();
    nChecks++;
    if (bus.pcmBits[3] !== 1'b0) begin
      nFails++;
      $display("FAIL en_rearm: got %b want 0", bus.pcmBits[3]);
    end
    bnd();
    nChecks++;
    if (bus.pcmBits[3] !== 1'b1) begin
      nFails++;
      $display("FAIL en_first: got %b want 1", bus.pcmBits[3]);
    end
    bnd();
    nChecks++;
    if (bus.pcmBits[3] !== 1'b0) begin
      nFails++;
      $display("FAIL en_second: got %b want 0", bus.pcmBits[3]);
    end
  endtask

  task automatic test_rnrz();
    logic [14:0] sr;
    logic [14:0] dsr;
    logic d;
    logic e;
    logic rec;
    do_reset();
    bus.pcmRandomize[0] = 1'b1;
    bus.nrzBits = '1;
    sr  = '0;
    dsr = '0;
    for (int k = 0; k < 40; k++) begin
`ifdef PCM_RNRZ_EN
      d  = 1'b1 ^ sr[13] ^ sr[14];
      sr = {sr[13:0], d};
`else
      d  = 1'b1;
`endif
      expQ.push_back(d);
      bnd();
      e = expQ.pop_front();
      nChecks++;
      if (bus.pcmBits[0] !== e) begin
        nFails++;
        $display("FAIL rnrz[%0d]: got %b want %b", k, bus.pcmBits[0], e);
      end
`ifdef PCM_RNRZ_EN
      rec = bus.pcmBits[0] ^ dsr[13] ^ dsr[14];
      dsr = {dsr[13:0], bus.pcmBits[0]};
`else
      rec = bus.pcmBits[0];
`endif
      nChecks++;
      if (rec !== 1'b1) begin
        nFails++;
        $display("FAIL descr[%0d]: got %b want 1", k, rec);
      end
    end
    nChecks++;
    if (bus.pcmBits[1] !== 1'b1) begin
      nFails++;
      $display("FAIL rnrz_plain_lane: got %b want 1", bus.pcmBits[1]);
    end
  endtask

  task automatic test_back_to_back();
    logic [NCH-1:0] v;
    logic [NCH-1:0] ev;
    do_reset();
    for (int k = 0; k < 12; k++) begin
      v = NCH'($urandom);
      bus.nrzBits = v;
      expVQ.push_back(v);
      bnd();
      ev = expVQ.pop_front();
      nChecks++;
      if (bus.pcmBits !== ev || bus.bitTaken !== 1'b1) begin
        nFails++;
        $display("FAIL b2b[%0d]: got %b/%b want %b/1",
                 k, bus.pcmBits, bus.bitTaken, ev);
      end
    end
  endtask

  initial begin
    bus.clkEn        = 1'b1;
    bus.sym2xClkEn   = 1'b0;
    bus.symClkEn     = 1'b0;
    bus.nrzBits      = '0;
    bus.pcmMode      = '0;
    bus.pcmInvert    = '0;
    bus.chEnable     = '1;
    bus.pcmRandomize = '0;
    test_reset();
    test_nrzl();
    test_nrzm_nrzs();
    test_biphase();
    test_dm();
    test_deferred();
    test_enable();
    test_rnrz();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFails);
    $finish;
  end
endmodule
